// File: rtl/mem_bus_ctrl_if.sv
// Pipeline-side memory bus between the MEM stage and mem_bus_ctrl.
// The pipeline is the master: it presents a word address, store data and a
// read/write request, and holds them while Busy is high. The controller is
// the slave: it returns registered load data and the stall request.
interface mem_bus_ctrl_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] DataOut;
    logic        Busy;

    modport master (
        output Addr, DataIn, MemRead, MemWrite,
        input  DataOut, Busy
    );

    modport slave (
        input  Addr, DataIn, MemRead, MemWrite,
        output DataOut, Busy
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences MEM-stage loads and stores onto an asynchronous
// SRAM (Ram1_*) and a memory-mapped UART that share the Ram1_data bus.
//
// Build option: define MEM_BUS_UART_EN to decode UART_DATA_ADDR /
// UART_STAT_ADDR onto the UART. Without it every address goes to the SRAM,
// rdn/wrn stay high and the UART status inputs are ignored.
//
// Every strobe comes straight from a flop, so each strobe value is decided
// on the edge that enters the state in which it must be active.
module mem_bus_ctrl #(
    parameter logic [15:0] UART_DATA_ADDR   = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR   = 16'hBF01,
    parameter int unsigned RD_STROBE_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    mem_bus_ctrl_if.slave   bus,
    output logic            Ram1_EN,
    output logic            Ram1_OE,
    output logic            Ram1_WE,
    output logic [17:0]     Ram1_address,
    inout  wire  [15:0]     Ram1_data,
    output logic            rdn,
    output logic            wrn,
    input  logic            data_ready,
    input  logic            tbre,
    input  logic            tsre
);

`ifdef MEM_BUS_UART_EN
    typedef enum logic [2:0] {
        IDLE, RAM_RD, RAM_WR1, RAM_WR2, UART_RD, UART_WR, UART_WAIT, DONE
    } state_t;

    // Index of the last rdn-low cycle for the 3-bit strobe counter.
    localparam logic [2:0] RD_LAST = 3'(RD_STROBE_CYCLES - 1);
`else
    typedef enum logic [2:0] {
        IDLE, RAM_RD, RAM_WR1, RAM_WR2, DONE
    } state_t;
`endif

    state_t      state_q;
    logic [15:0] dout_q;
    logic        en_q;
    logic        oe_q;
    logic        we_q;
    logic        drv_q;
`ifdef MEM_BUS_UART_EN
    logic        rdn_q;
    logic        wrn_q;
    logic [2:0]  cnt_q;
`endif

    // Access sequencer: state, load data and all strobes in one register block.
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: every strobe is reset to its idle level so an access in
        // flight is abandoned the instant Rst falls, not at the next edge.
        if (!Rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            en_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drv_q   <= 1'b0;
`ifdef MEM_BUS_UART_EN
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            cnt_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register in this block
            // reading the pre-edge values, whatever order the branches run in.
            case (state_q)
                IDLE: begin
                    // A store is checked first, so write wins when both are held.
                    if (bus.MemWrite) begin
`ifdef MEM_BUS_UART_EN
                        if (bus.Addr == UART_DATA_ADDR) begin
                            state_q <= UART_WR;
                            wrn_q   <= 1'b0;
                            drv_q   <= 1'b1;
                        end else begin
                            state_q <= RAM_WR1;
                            en_q    <= 1'b0;
                            we_q    <= 1'b0;
                            drv_q   <= 1'b1;
                        end
`else
                        state_q <= RAM_WR1;
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        drv_q   <= 1'b1;
`endif
                    end else if (bus.MemRead) begin
`ifdef MEM_BUS_UART_EN
                        if (bus.Addr == UART_DATA_ADDR) begin
                            state_q <= UART_RD;
                            rdn_q   <= 1'b0;
                            cnt_q   <= '0;
                        end else if (bus.Addr == UART_STAT_ADDR) begin
                            // Status is sampled in the request cycle itself.
                            state_q <= DONE;
                            dout_q  <= {14'b0, data_ready, tbre & tsre};
                        end else begin
                            state_q <= RAM_RD;
                            en_q    <= 1'b0;
                            oe_q    <= 1'b0;
                        end
`else
                        state_q <= RAM_RD;
                        en_q    <= 1'b0;
                        oe_q    <= 1'b0;
`endif
                    end
                end

                RAM_RD: begin
                    dout_q  <= Ram1_data;
                    en_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    state_q <= DONE;
                end

                RAM_WR1: begin
                    // WE rises while data stays on the bus for hold time.
                    we_q    <= 1'b1;
                    state_q <= RAM_WR2;
                end

                RAM_WR2: begin
                    en_q    <= 1'b1;
                    drv_q   <= 1'b0;
                    state_q <= DONE;
                end

`ifdef MEM_BUS_UART_EN
                UART_RD: begin
                    if (cnt_q == RD_LAST) begin
                        dout_q  <= Ram1_data;
                        rdn_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end

                UART_WR: begin
                    wrn_q   <= 1'b1;
                    drv_q   <= 1'b0;
                    state_q <= UART_WAIT;
                end

                UART_WAIT: begin
                    // Transmitter must be fully empty before the store retires.
                    if (tbre & tsre) begin
                        state_q <= DONE;
                    end
                end
`endif

                DONE: begin
                    // The pipeline still holds the request here; it is ignored.
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    we_q    <= 1'b1;
                    drv_q   <= 1'b0;
                end
            endcase
        end
    end

    // Stall while a request waits in IDLE or any access state is active.
    assign bus.Busy = Rst &&
                      (((state_q == IDLE) && (bus.MemRead || bus.MemWrite)) ||
                       ((state_q != IDLE) && (state_q != DONE)));

    assign bus.DataOut  = dout_q;
    assign Ram1_address = {2'b00, bus.Addr};
    assign Ram1_EN      = en_q;
    assign Ram1_OE      = oe_q;
    assign Ram1_WE      = we_q;
    assign Ram1_data    = drv_q ? bus.DataIn : 16'hzzzz;

`ifdef MEM_BUS_UART_EN
    assign rdn = rdn_q;
    assign wrn = wrn_q;
`else
    assign rdn = 1'b1;
    assign wrn = 1'b1;

    // UART status and addresses have no function in an SRAM-only build.
    logic unused_uart;
    assign unused_uart = ^{data_ready, tbre, tsre,
                           UART_DATA_ADDR, UART_STAT_ADDR, RD_STROBE_CYCLES};
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl. Each access pushes its hand-computed
// expectation; a negedge monitor measures busy/strobe widths over the access
// and compares them when the DUT drops Busy with the request still held.
// UART cases run when MEM_BUS_UART_EN is defined, SRAM-only aliases otherwise.
module tb_mem_bus_ctrl;

    typedef struct {
        string       name;
        logic [15:0] dout;
        int          busy;
        int          oe;
        int          we;
        int          drv;
        int          rdn;
        int          wrn;
    } exp_t;

    logic clk;
    logic rst_n;
    logic Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn;
    logic [17:0] Ram1_address;
    wire  [15:0] Ram1_data;
    logic data_ready, tbre, tsre;

    logic [15:0] mem [0:65535];
    logic [15:0] uart_val;
    logic        tb_drv;
    logic [15:0] tb_val;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   c_busy, c_oe, c_we, c_drv, c_rdn, c_wrn, c_addr;
    bit   txn_done;

    mem_bus_ctrl_if bus_if ();

    mem_bus_ctrl dut (
        .Clk          (clk),
        .Rst          (rst_n),
        .bus          (bus_if),
        .Ram1_EN      (Ram1_EN),
        .Ram1_OE      (Ram1_OE),
        .Ram1_WE      (Ram1_WE),
        .Ram1_address (Ram1_address),
        .Ram1_data    (Ram1_data),
        .rdn          (rdn),
        .wrn          (wrn),
        .data_ready   (data_ready),
        .tbre         (tbre),
        .tsre         (tsre)
    );

    // Weak pull-ups make a released bus read as FFFF, which no test drives.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup pu (Ram1_data[i]);
    end

    // SRAM and UART receive-register models driving the shared bus.
    assign tb_drv    = (!Ram1_EN && !Ram1_OE) || !rdn;
    assign tb_val    = !rdn ? uart_val : mem[Ram1_address[15:0]];
    assign Ram1_data = tb_drv ? tb_val : 16'hzzzz;

    always @(negedge clk) begin
        if (rst_n && !Ram1_EN && !Ram1_WE) mem[Ram1_address[15:0]] <= Ram1_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        c_busy = 0; c_oe = 0; c_we = 0; c_drv = 0; c_rdn = 0; c_wrn = 0; c_addr = 0;
    endtask

    // Monitor: accumulate per-access widths, compare on completion.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            clear_counts();
        end else if (bus_if.MemRead || bus_if.MemWrite) begin
            if (!Ram1_OE) c_oe++;
            if (!Ram1_WE) c_we++;
            if (!rdn)     c_rdn++;
            if (!wrn)     c_wrn++;
            if (Ram1_address !== {2'b00, bus_if.Addr}) c_addr++;
            if (!tb_drv && Ram1_data !== 16'hFFFF) begin
                if (Ram1_data === bus_if.DataIn) c_drv++;
                else c_drv += 100;
            end
            if (bus_if.Busy) begin
                c_busy++;
            end else begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check({e.name, ".dout"}, bus_if.DataOut, e.dout);
                    check({e.name, ".busy"}, c_busy, e.busy);
                    check({e.name, ".oe_low"}, c_oe, e.oe);
                    check({e.name, ".we_low"}, c_we, e.we);
                    check({e.name, ".bus_driven"}, c_drv, e.drv);
                    check({e.name, ".rdn_low"}, c_rdn, e.rdn);
                    check({e.name, ".wrn_low"}, c_wrn, e.wrn);
                    check({e.name, ".addr_err"}, c_addr, 0);
                end
                clear_counts();
                txn_done = 1'b1;
            end
        end
    end

    function automatic exp_t mk(input string name, input logic [15:0] dout, input int busy,
                                input int oe, input int we, input int drv,
                                input int rdn_n, input int wrn_n);
        exp_t e;
        e.name = name; e.dout = dout; e.busy = busy; e.oe = oe; e.we = we;
        e.drv = drv; e.rdn = rdn_n; e.wrn = wrn_n;
        return e;
    endfunction

    // Issue one access, hold it until the monitor sees it retire (bounded).
    // If tsre_low > 0, tsre is held low for that many cycles from the request.
    task automatic do_access(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [15:0] din, input exp_t e, input int tsre_low);
        sb.push_back(e);
        @(posedge clk); #1;
        txn_done        = 1'b0;
        bus_if.Addr     = addr;
        bus_if.DataIn   = din;
        bus_if.MemRead  = rd;
        bus_if.MemWrite = wr;
        if (tsre_low > 0) tsre = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (i == tsre_low) tsre = 1'b1;
            if (txn_done) break;
        end
        check({e.name, ".retired"}, txn_done, 1);
        if (!txn_done) sb.delete();
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        n_cmp = 0; n_bad = 0; txn_done = 1'b0;
        clear_counts();
        rst_n = 1'b0;
        data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
        uart_val = 16'h005A;
        bus_if.Addr = 16'h0040; bus_if.DataIn = 16'h0000;
        bus_if.MemRead = 1'b1;  bus_if.MemWrite = 1'b0;
        mem[16'h0040] = 16'h1234;
        mem[16'h0041] = 16'h0000;
        mem[16'h0050] = 16'h0000;
        mem[16'hBF00] = 16'h7777;
        mem[16'hBF01] = 16'h2222;

        // Reset state, with a request held to show Busy is forced low.
        repeat (3) @(negedge clk);
        check("rst.dout", bus_if.DataOut, 16'h0000);
        check("rst.busy", bus_if.Busy, 0);
        check("rst.ram_strobes", {Ram1_EN, Ram1_OE, Ram1_WE}, 3'b111);
        check("rst.uart_strobes", {rdn, wrn}, 2'b11);
        check("rst.bus_released", Ram1_data, 16'hFFFF);
        bus_if.MemRead = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_access(1, 0, 16'h0040, 16'h0000, mk("load_40", 16'h1234, 2, 1, 0, 0, 0, 0), 0);
        do_access(0, 1, 16'h0041, 16'hBEEF, mk("store_41", 16'h1234, 3, 0, 1, 2, 0, 0), 0);
        check("sram_41", mem[16'h0041], 16'hBEEF);
        do_access(1, 1, 16'h0050, 16'h5150, mk("rw_both_50", 16'h1234, 3, 0, 1, 2, 0, 0), 0);
        check("sram_50", mem[16'h0050], 16'h5150);
        do_access(1, 0, 16'h0041, 16'h0000, mk("load_41", 16'hBEEF, 2, 1, 0, 0, 0, 0), 0);

`ifdef MEM_BUS_UART_EN
        do_access(0, 1, 16'hBF00, 16'h0041, mk("uart_wr", 16'hBEEF, 6, 0, 0, 1, 0, 1), 5);
        check("uart_wr.sram_untouched", mem[16'hBF00], 16'h7777);
        data_ready = 1'b1;
        do_access(1, 0, 16'hBF01, 16'h0000, mk("uart_stat", 16'h0003, 1, 0, 0, 0, 0, 0), 0);
        do_access(1, 0, 16'hBF00, 16'h0000, mk("uart_rd", 16'h005A, 3, 0, 0, 0, 2, 0), 0);
`else
        tsre = 1'b0;
        data_ready = 1'b1;
        do_access(0, 1, 16'hBF00, 16'h0041, mk("bf00_store", 16'hBEEF, 3, 0, 1, 2, 0, 0), 0);
        check("sram_bf00", mem[16'hBF00], 16'h0041);
        do_access(1, 0, 16'hBF01, 16'h0000, mk("bf01_load", 16'h2222, 2, 1, 0, 0, 0, 0), 0);
        do_access(1, 0, 16'hBF00, 16'h0000, mk("bf00_load", 16'h0041, 2, 1, 0, 0, 0, 0), 0);
        tsre = 1'b1;
`endif

        // Reset in the middle of a store: strobes and bus drop immediately.
        @(posedge clk); #1;
        bus_if.Addr = 16'h0060; bus_if.DataIn = 16'h6060; bus_if.MemWrite = 1'b1;
        @(posedge clk); #2;
        check("midrst.in_wr1", {Ram1_EN, Ram1_WE}, 2'b00);
        rst_n = 1'b0;
        #1;
        check("midrst.we", Ram1_WE, 1);
        check("midrst.en", Ram1_EN, 1);
        check("midrst.wrn", wrn, 1);
        check("midrst.bus_released", Ram1_data, 16'hFFFF);
        check("midrst.dout", bus_if.DataOut, 16'h0000);
        check("midrst.busy", bus_if.Busy, 0);
        bus_if.MemWrite = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_access(1, 0, 16'h0040, 16'h0000, mk("load_after_rst", 16'h1234, 2, 1, 0, 0, 0, 0), 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
